// File: rtl/trace_tx_pkg.sv
// Shared encodings for the trace transmit arbiter: FSM states, TPIU sync pattern,
// frame geometry and grant identifiers.
package trace_tx_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSync  = 2'd1;
  localparam logic [1:0] StFrame = 2'd2;
  localparam logic [1:0] StStat  = 2'd3;

  localparam int unsigned SYNC_LEN    = 4;
  localparam int unsigned FRAME_BYTES = 16;

  // TPIU full sync, byte 0 in the low lane: FF FF FF 7F on the wire.
  localparam logic [31:0] SYNC_BYTES = 32'h7FFF_FFFF;

  localparam logic GRANT_FRAME = 1'b0;
  localparam logic GRANT_STAT  = 1'b1;

  localparam logic [3:0] SYNC_LAST  = 4'(SYNC_LEN - 1);
  localparam logic [3:0] FRAME_LAST = 4'(FRAME_BYTES - 1);
  localparam logic [3:0] STAT_LAST  = 4'd1;

  function automatic logic [7:0] frame_byte(input logic [127:0] frame, input logic [3:0] k);
    return frame[{k, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] sync_byte(input logic [1:0] k);
    return SYNC_BYTES[{k, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/trace_tx_arbiter_if.sv
// Byte-stream and requester handshake bundle around the trace transmit arbiter.
// master: the arbiter; slave: frame buffer, status logic and UART TX side.
interface trace_tx_arbiter_if;

  logic         frame_valid;
  logic [127:0] frame_data;
  logic         frame_ready;
  logic         stat_valid;
  logic [7:0]   stat_byte;
  logic         stat_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;

  modport master (
    input  frame_valid,
    input  frame_data,
    output frame_ready,
    input  stat_valid,
    input  stat_byte,
    output stat_ready,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    output frame_valid,
    output frame_data,
    input  frame_ready,
    output stat_valid,
    output stat_byte,
    input  stat_ready,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/led_stretch.sv
// Retriggerable pulse stretcher for the transmit LED. Only built when TRACE_TX_LED_EN
// is defined, so the LED-less build carries no counter.
`ifdef TRACE_TX_LED_EN
module led_stretch #(
  parameter int unsigned HOLD_CYCLES = 4800000
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  output logic led
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (pulse) begin
      cnt_d = CntW'(HOLD_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign led = (cnt_q != '0);

endmodule
`endif

// File: rtl/trace_tx_arbiter.sv
// Shares the UART TX byte stream between TPIU trace frames and status reports, inserting
// TPIU full-sync periodically. Optional LED stretcher under TRACE_TX_LED_EN.
module trace_tx_arbiter
  import trace_tx_pkg::*;
#(
  parameter int unsigned SYNC_INTERVAL   = 16,
  parameter logic [7:0]  STAT_MARK       = 8'hA5,
  parameter int unsigned LED_HOLD_CYCLES = 4800000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_en,
  trace_tx_arbiter_if.master  bus,
  output logic                busy,
  output logic                tx_led
);

  localparam int unsigned     CntW    = $clog2(SYNC_INTERVAL + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SYNC_INTERVAL - 1);

  logic [1:0]      state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [127:0]    shadow_q, shadow_d;
  logic [7:0]      stat_q, stat_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sync_due_q, sync_due_d;
  logic            last_grant_q, last_grant_d;

  logic            grant_sync, grant_frame, grant_stat;
  logic            hs, last_byte;
  logic [3:0]      idx_next, last_idx;
  logic [7:0]      next_byte;

  // Arbitration happens only in IDLE; a pending sync is sent only ahead of real traffic.
  always_comb begin
    grant_sync  = 1'b0;
    grant_frame = 1'b0;
    grant_stat  = 1'b0;
    if (state_q == StIdle && tx_en && !rst && (bus.frame_valid || bus.stat_valid)) begin
      if (sync_due_q) begin
        grant_sync = 1'b1;
      end else if (bus.frame_valid && bus.stat_valid) begin
        grant_frame = (last_grant_q == GRANT_STAT);
        grant_stat  = (last_grant_q == GRANT_FRAME);
      end else begin
        grant_frame = bus.frame_valid;
        grant_stat  = bus.stat_valid;
      end
    end
  end

  assign hs       = tx_valid_q && bus.tx_ready;
  assign idx_next = idx_q + 4'd1;

  always_comb begin
    unique case (state_q)
      StSync:  last_idx = SYNC_LAST;
      StFrame: last_idx = FRAME_LAST;
      StStat:  last_idx = STAT_LAST;
      default: last_idx = 4'd0;
    endcase
  end

  assign last_byte = (idx_q == last_idx);

  always_comb begin
    unique case (state_q)
      StSync:  next_byte = sync_byte(idx_next[1:0]);
      StFrame: next_byte = frame_byte(shadow_q, idx_next);
      StStat:  next_byte = stat_q;
      default: next_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    stat_d       = stat_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    cnt_d        = cnt_q;
    sync_due_d   = sync_due_q;
    last_grant_d = last_grant_q;

    if (state_q == StIdle) begin
      if (grant_sync) begin
        state_d    = StSync;
        idx_d      = 4'd0;
        tx_valid_d = 1'b1;
        tx_data_d  = sync_byte(2'd0);
      end else if (grant_frame) begin
        state_d      = StFrame;
        idx_d        = 4'd0;
        shadow_d     = bus.frame_data;
        tx_valid_d   = 1'b1;
        tx_data_d    = frame_byte(bus.frame_data, 4'd0);
        last_grant_d = GRANT_FRAME;
      end else if (grant_stat) begin
        state_d      = StStat;
        idx_d        = 4'd0;
        stat_d       = bus.stat_byte;
        tx_valid_d   = 1'b1;
        tx_data_d    = STAT_MARK;
        last_grant_d = GRANT_STAT;
      end
    end else if (hs) begin
      if (last_byte) begin
        state_d    = StIdle;
        tx_valid_d = 1'b0;
        if (state_q == StSync) begin
          sync_due_d = 1'b0;
        end
        if (state_q == StFrame) begin
          if (cnt_q == CntLast) begin
            cnt_d      = '0;
            sync_due_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end else begin
        idx_d     = idx_next;
        tx_data_d = next_byte;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= 4'd0;
      shadow_q     <= '0;
      stat_q       <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      cnt_q        <= '0;
      sync_due_q   <= 1'b1;
      last_grant_q <= GRANT_STAT;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      stat_q       <= stat_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      cnt_q        <= cnt_d;
      sync_due_q   <= sync_due_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.frame_ready = grant_frame;
  assign bus.stat_ready  = grant_stat;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_valid    = tx_valid_q;
  assign busy            = (state_q != StIdle);

`ifdef TRACE_TX_LED_EN
  led_stretch #(
    .HOLD_CYCLES(LED_HOLD_CYCLES)
  ) u_led_stretch (
    .clk  (clk),
    .rst  (rst),
    .pulse(hs),
    .led  (tx_led)
  );
`else
  // LED disabled: the hold length still participates so both builds share one parameter set.
  assign tx_led = 1'b0 & (LED_HOLD_CYCLES != 0);
`endif

endmodule

// File: tb/tb_trace_tx_arbiter.sv
// Self-checking bench for trace_tx_arbiter: vector table plus directed sequences, with a
// byte scoreboard fed at stimulus time and drained by a negedge monitor.
module tb_trace_tx_arbiter;

  localparam int unsigned SyncInterval = 2;
  localparam int unsigned LedHold      = 10;
  localparam logic [7:0]  StatMark     = 8'hA5;
`ifdef TRACE_TX_LED_EN
  localparam int ExpLedCycles = 10;
`else
  localparam int ExpLedCycles = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_en = 1'b1;
  logic busy;
  logic tx_led;

  trace_tx_arbiter_if bus ();

  trace_tx_arbiter #(
    .SYNC_INTERVAL  (SyncInterval),
    .STAT_MARK      (StatMark),
    .LED_HOLD_CYCLES(LedHold)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tx_en (tx_en),
    .bus   (bus),
    .busy  (busy),
    .tx_led(tx_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          do_frame;
    logic [7:0]  seed;
    bit          do_stat;
    logic [7:0]  stat;
    int          mode;
    int          exp_fr;
    int          exp_st;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int hs_count = 0;
  int frame_pulses = 0;
  int stat_pulses = 0;
  int ready_mode = 0;
  bit stall_seen = 1'b0;
  logic [7:0] stall_data = 8'h00;

  // Reference model state
  bit m_sync_due;
  int m_cnt;
  bit m_last_stat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [127:0] make_frame(input logic [7:0] seed);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = seed + 8'(k);
    return r;
  endfunction

  task automatic model_reset();
    m_sync_due  = 1'b1;
    m_cnt       = 0;
    m_last_stat = 1'b1;
    exp_q.delete();
  endtask

  task automatic push_sync();
    if (m_sync_due) begin
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h7F);
      m_sync_due = 1'b0;
    end
  endtask

  task automatic push_frame(input logic [127:0] f);
    push_sync();
    for (int k = 0; k < 16; k++) exp_q.push_back(f[k*8 +: 8]);
    m_cnt++;
    if (m_cnt == int'(SyncInterval)) begin
      m_cnt      = 0;
      m_sync_due = 1'b1;
    end
    m_last_stat = 1'b0;
  endtask

  task automatic push_stat(input logic [7:0] b);
    push_sync();
    exp_q.push_back(StatMark);
    exp_q.push_back(b);
    m_last_stat = 1'b1;
  endtask

  // tx_ready pattern: 0 always, 1 toggle, 2 random, other forced low
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = ~bus.tx_ready;
        2:       bus.tx_ready = 1'($urandom_range(0, 1));
        default: bus.tx_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_seen = 1'b0;
      end else begin
        if (stall_seen) begin
          chk("hold_valid", 32'(bus.tx_valid), 32'd1);
          chk("hold_data", 32'(bus.tx_data), 32'(stall_data));
        end
        if (bus.frame_ready) frame_pulses++;
        if (bus.stat_ready) stat_pulses++;
        if (bus.tx_valid && bus.tx_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_byte_unexpected: got %02h, required no byte", bus.tx_data);
          end else begin
            chk("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
          end
        end
        stall_seen = bus.tx_valid && !bus.tx_ready;
        stall_data = bus.tx_data;
      end
    end
  end

  task automatic wait_grant(input bit is_stat, input bit release_req, input string name);
    int base = is_stat ? stat_pulses : frame_pulses;
    int n = 0;
    while (((is_stat ? stat_pulses : frame_pulses) == base) && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_grant"}, 32'((is_stat ? stat_pulses : frame_pulses) - base), 32'd1);
    @(posedge clk);
    #1;
    if (release_req) begin
      if (is_stat) bus.stat_valid = 1'b0;
      else bus.frame_valid = 1'b0;
    end
  endtask

  task automatic wait_hs(input int target, input string name);
    int n = 0;
    while (hs_count < target && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_reached"}, 32'(hs_count >= target), 32'd1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset(input string name);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk({name, "_tx_valid_drop"}, 32'(bus.tx_valid), 32'd0);
    chk({name, "_busy_drop"}, 32'(busy), 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk({name, "_tx_data"}, 32'(bus.tx_data), 32'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    logic [127:0] f = make_frame(v.seed);
    bit first_stat = 1'b0;
    int f0, s0;
    string name = $sformatf("vec%0d", i);
    ready_mode = v.mode;
    if (v.do_frame && v.do_stat) begin
      if (m_last_stat) begin
        push_frame(f);
        push_stat(v.stat);
      end else begin
        first_stat = 1'b1;
        push_stat(v.stat);
        push_frame(f);
      end
    end else if (v.do_frame) begin
      push_frame(f);
    end else if (v.do_stat) begin
      push_stat(v.stat);
    end
    f0 = frame_pulses;
    s0 = stat_pulses;
    @(posedge clk);
    #1;
    bus.frame_valid = v.do_frame;
    bus.frame_data  = f;
    bus.stat_valid  = v.do_stat;
    bus.stat_byte   = v.stat;
    if (v.do_frame && v.do_stat) begin
      wait_grant(first_stat, 1'b1, name);
      wait_grant(!first_stat, 1'b1, name);
    end else begin
      wait_grant(v.do_stat, 1'b1, name);
    end
    drain(name);
    chk({name, "_frame_pulses"}, 32'(frame_pulses - f0), 32'(v.exp_fr));
    chk({name, "_stat_pulses"}, 32'(stat_pulses - s0), 32'(v.exp_st));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] f;
    int base, syncn, sp, led_cnt, n;

    vecs[0] = '{1'b1, 8'h00, 1'b0, 8'h00, 0, 1, 0};
    vecs[1] = '{1'b1, 8'h20, 1'b0, 8'h00, 1, 1, 0};
    vecs[2] = '{1'b1, 8'h30, 1'b1, 8'h3C, 0, 1, 1};
    vecs[3] = '{1'b1, 8'h50, 1'b1, 8'h5A, 2, 1, 1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h81, 1, 0, 1};
    vecs[5] = '{1'b1, 8'h70, 1'b1, 8'h7E, 0, 1, 1};

    bus.frame_valid = 1'b0;
    bus.frame_data  = '0;
    bus.stat_valid  = 1'b0;
    bus.stat_byte   = 8'h00;
    bus.tx_ready    = 1'b1;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("reset_tx_data", 32'(bus.tx_data), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame_ready", 32'(bus.frame_ready), 32'd0);
    chk("reset_stat_ready", 32'(bus.stat_ready), 32'd0);
    chk("reset_tx_led", 32'(tx_led), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Back-to-back frames after reset: sync ahead of frames 1, 3 and 5 only
    do_reset("b2b_rst");
    ready_mode = 0;
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      f = make_frame(8'h40 + 8'(i * 16));
      bus.frame_data = f;
      push_frame(f);
      wait_grant(1'b0, 1'b0, $sformatf("b2b%0d", i));
    end
    bus.frame_valid = 1'b0;
    drain("b2b");

    // Reset while byte 7 of a frame is on the bus
    ready_mode = 0;
    syncn = m_sync_due ? 4 : 0;
    f = make_frame(8'hC0);
    base = hs_count;
    push_frame(f);
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b1;
    bus.frame_data  = f;
    wait_grant(1'b0, 1'b1, "rstmid");
    wait_hs(base + syncn + 7, "rstmid_byte6");
    ready_mode = 3;
    @(negedge clk);
    #1;
    chk("rstmid_byte7_valid", 32'(bus.tx_valid), 32'd1);
    chk("rstmid_byte7_data", 32'(bus.tx_data), 32'hC7);
    do_reset("rstmid_rst");
    ready_mode = 0;
    f = make_frame(8'hD0);
    push_frame(f);
    sp = frame_pulses;
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b1;
    bus.frame_data  = f;
    wait_grant(1'b0, 1'b1, "rstmid_new");
    drain("rstmid_new");
    chk("rstmid_single_pulse", 32'(frame_pulses - sp), 32'd1);

    // tx_en drops at frame byte 3; pending status held until re-enabled
    syncn = m_sync_due ? 4 : 0;
    f = make_frame(8'h60);
    base = hs_count;
    push_frame(f);
    @(posedge clk);
    #1;
    bus.frame_valid = 1'b1;
    bus.frame_data  = f;
    wait_grant(1'b0, 1'b1, "enoff");
    wait_hs(base + syncn + 3, "enoff_byte3");
    tx_en = 1'b0;
    bus.stat_valid = 1'b1;
    bus.stat_byte  = 8'h99;
    sp = stat_pulses;
    drain("enoff_frame");
    repeat (20) @(negedge clk);
    #1;
    chk("enoff_no_stat_grant", 32'(stat_pulses - sp), 32'd0);
    chk("enoff_idle", 32'(busy), 32'd0);
    push_stat(8'h99);
    tx_en = 1'b1;
    wait_grant(1'b1, 1'b1, "enon");
    drain("enon");

    // LED stretch after the final handshake of a status packet
    ready_mode = 0;
    push_stat(8'h11);
    @(posedge clk);
    #1;
    bus.stat_valid = 1'b1;
    bus.stat_byte  = 8'h11;
    wait_grant(1'b1, 1'b1, "led");
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("led_queue_left", 32'(exp_q.size()), 32'd0);
    led_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_led) led_cnt++;
    end
    chk("led_high_cycles", 32'(led_cnt), 32'(ExpLedCycles));
    chk("led_final", 32'(tx_led), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
